// File: rtl/fp_compare_unit_if.sv
// Request/response bundle shared by the board-level driver FSM and fp_compare_unit.
// The driver owns operands/op_code/mode/start; the unit owns result/flags/valid_out/busy.
interface fp_compare_unit_if;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [2:0]  op_code;
   logic        mode_fp;
   logic        start;
   logic [31:0] result;
   logic [4:0]  flags;
   logic        valid_out;
   logic        busy;

   modport master (
      output op_a, op_b, op_code, mode_fp, start,
      input  result, flags, valid_out, busy
   );

   modport slave (
      input  op_a, op_b, op_code, mode_fp, start,
      output result, flags, valid_out, busy
   );
endinterface

// File: rtl/fp_compare_unit.sv
// Fixed-latency FP compare/min/max/classify unit (single and half precision).
// Define FP_CMP_STICKY_FLAGS_EN to add clear_flags/sticky_flags accumulation.
module fp_compare_unit (
   input  logic              clk,
   input  logic              rst,
   fp_compare_unit_if.slave  bus
`ifdef FP_CMP_STICKY_FLAGS_EN
   ,
   input  logic              clear_flags,
   output logic [4:0]        sticky_flags
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_UNPACK, ST_CMP, ST_DONE} state_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
      logic        zero;
      logic        sub;
      logic        inf;
      logic        nan;
      logic        snan;
   } fp_fields_t;

   // Half operands are zero-extended so one magnitude comparator serves both formats.
   function automatic fp_fields_t unpack_fp(input logic [31:0] v, input logic half);
      fp_fields_t f;
      logic       exp_max;
      logic       quiet;
      f.sign  = half ? v[15] : v[31];
      f.exp   = half ? {3'b000, v[14:10]} : v[30:23];
      f.man   = half ? {13'b0, v[9:0]} : v[22:0];
      exp_max = half ? (v[14:10] == 5'h1f) : (v[30:23] == 8'hff);
      quiet   = half ? v[9] : v[22];
      f.zero  = (f.exp == 8'h00) && (f.man == 23'h0);
      f.sub   = (f.exp == 8'h00) && (f.man != 23'h0);
      f.inf   = exp_max && (f.man == 23'h0);
      f.nan   = exp_max && (f.man != 23'h0);
      f.snan  = f.nan && !quiet;
      return f;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [2:0]  opc_q, opc_d;
   logic        half_q, half_d;
   fp_fields_t  fa_q, fa_d, fb_q, fb_d;
   logic [31:0] res_q, res_d;
   logic [4:0]  flg_q, flg_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  flags_q, flags_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
`ifdef FP_CMP_STICKY_FLAGS_EN
   logic [4:0]  sticky_q, sticky_d;
`endif

   logic [31:0] cmp_res;
   logic [4:0]  cmp_flg;
   logic [30:0] mag_a, mag_b;
   logic        mag_lt, mag_eq, both_zero, any_nan, any_snan;
   logic        ord_eq, ord_lt, tot_lt, sign_diff, norm_a;
   logic [31:0] val_a, val_b, canon_qnan;
   logic [9:0]  cls;

   // Result computation for the CMP stage, from the registered unpacked operands.
   always_comb begin
      mag_a      = {fa_q.exp, fa_q.man};
      mag_b      = {fb_q.exp, fb_q.man};
      mag_lt     = mag_a < mag_b;
      mag_eq     = mag_a == mag_b;
      sign_diff  = fa_q.sign != fb_q.sign;
      both_zero  = fa_q.zero && fb_q.zero;
      any_nan    = fa_q.nan || fb_q.nan;
      any_snan   = fa_q.snan || fb_q.snan;
      // tot_lt orders -0 below +0; ord_lt treats the two zeros as equal.
      tot_lt     = sign_diff ? fa_q.sign : (fa_q.sign ? (!mag_lt && !mag_eq) : mag_lt);
      ord_lt     = !both_zero && tot_lt;
      ord_eq     = both_zero || (!sign_diff && mag_eq);
      val_a      = half_q ? {16'h0000, a_q[15:0]} : a_q;
      val_b      = half_q ? {16'h0000, b_q[15:0]} : b_q;
      canon_qnan = half_q ? 32'h0000_7E00 : 32'h7FC0_0000;
      norm_a     = !fa_q.zero && !fa_q.sub && !fa_q.inf && !fa_q.nan;
      cls        = '0;
      cls[0]     = fa_q.inf  &&  fa_q.sign;
      cls[1]     = norm_a    &&  fa_q.sign;
      cls[2]     = fa_q.sub  &&  fa_q.sign;
      cls[3]     = fa_q.zero &&  fa_q.sign;
      cls[4]     = fa_q.zero && !fa_q.sign;
      cls[5]     = fa_q.sub  && !fa_q.sign;
      cls[6]     = norm_a    && !fa_q.sign;
      cls[7]     = fa_q.inf  && !fa_q.sign;
      cls[8]     = fa_q.snan;
      cls[9]     = fa_q.nan  && !fa_q.snan;
      cmp_res    = 32'h0;
      cmp_flg    = 5'b00000;
      case (opc_q)
         3'b000: begin
            cmp_res = {31'h0, !any_nan && ord_eq};
            cmp_flg = {any_snan, 4'b0000};
         end
         3'b001: begin
            cmp_res = {31'h0, !any_nan && ord_lt};
            cmp_flg = {any_nan, 4'b0000};
         end
         3'b010: begin
            cmp_res = {31'h0, !any_nan && (ord_lt || ord_eq)};
            cmp_flg = {any_nan, 4'b0000};
         end
         3'b011, 3'b100: begin
            if (fa_q.nan && fb_q.nan)  cmp_res = canon_qnan;
            else if (fa_q.nan)         cmp_res = val_b;
            else if (fb_q.nan)         cmp_res = val_a;
            else if (opc_q == 3'b011)  cmp_res = tot_lt ? val_a : val_b;
            else                       cmp_res = tot_lt ? val_b : val_a;
            cmp_flg = {any_snan, 4'b0000};
         end
         3'b101:  cmp_res = {22'h0, cls};
         default: cmp_flg = 5'b10000;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      opc_d    = opc_q;
      half_d   = half_q;
      fa_d     = fa_q;
      fb_d     = fb_q;
      res_d    = res_q;
      flg_d    = flg_q;
      result_d = result_q;
      flags_d  = flags_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
`ifdef FP_CMP_STICKY_FLAGS_EN
      sticky_d = clear_flags ? 5'b00000 : sticky_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               opc_d   = bus.op_code;
               half_d  = bus.mode_fp;
               busy_d  = 1'b1;
               state_d = ST_UNPACK;
            end
         end
         ST_UNPACK: begin
            fa_d    = unpack_fp(a_q, half_q);
            fb_d    = unpack_fp(b_q, half_q);
            state_d = ST_CMP;
         end
         ST_CMP: begin
            res_d   = cmp_res;
            flg_d   = cmp_flg;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            result_d = res_q;
            flags_d  = flg_q;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
`ifdef FP_CMP_STICKY_FLAGS_EN
            // A concurrent clear still keeps the flags of the op completing now.
            sticky_d = clear_flags ? flg_q : (sticky_q | flg_q);
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         opc_q    <= '0;
         half_q   <= 1'b0;
         fa_q     <= '0;
         fb_q     <= '0;
         res_q    <= '0;
         flg_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef FP_CMP_STICKY_FLAGS_EN
         sticky_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opc_q    <= opc_d;
         half_q   <= half_d;
         fa_q     <= fa_d;
         fb_q     <= fb_d;
         res_q    <= res_d;
         flg_q    <= flg_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef FP_CMP_STICKY_FLAGS_EN
         sticky_q <= sticky_d;
`endif
      end
   end

   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
   assign bus.valid_out = valid_q;
   assign bus.busy      = busy_q;
`ifdef FP_CMP_STICKY_FLAGS_EN
   assign sticky_flags  = sticky_q;
`endif

endmodule
